// File: rtl/turfio_ps_scan.sv
// turfio_ps_scan: MMCM fine-phase-shift controller for TURFIO RXCLK alignment.
// Accepts step / sweep / goto commands, drives the MMCM PSEN/PSINCDEC handshake,
// tracks the current phase position modulo one RXCLK period, and during a sweep
// records the first 0->1 transition of the phase-detector sample.
// Optional build macro TURFIO_PS_SCAN_DEC_EN: enables decrementing steps
// (signed step argument) and shortest-direction goto.
module turfio_ps_scan #(
    parameter int STEPS_PER_CYCLE = 672,
    parameter int NSTEP_BITS      = 10,
    parameter int NSETTLE         = 16,
    parameter int DONE_TIMEOUT    = 64
) (
    input  logic                  ps_clk_i,
    input  logic                  rst_i,
    input  logic                  mmcm_locked_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [NSTEP_BITS-1:0] cmd_arg_i,
    input  logic                  sample_i,
    output logic                  ps_en_o,
    output logic                  ps_incdec_o,
    input  logic                  ps_done_i,
    output logic [NSTEP_BITS-1:0] pos_o,
    output logic [NSTEP_BITS-1:0] edge_o,
    output logic                  edge_valid_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [NSTEP_BITS-1:0] SPC_N = NSTEP_BITS'(STEPS_PER_CYCLE);
    localparam logic [NSTEP_BITS-1:0] SMAX  = NSTEP_BITS'(STEPS_PER_CYCLE - 1);
    localparam int TMAX = (NSETTLE > DONE_TIMEOUT) ? NSETTLE : DONE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, SAMPLE} state_t;

    state_t                state;
    logic [NSTEP_BITS-1:0] remaining;   // steps still to issue in this command
    logic [TW-1:0]         timer;       // shared by done timeout and settle delay
    logic                  dec;         // direction of the current command
    logic                  sweeping;
    logic                  prev;        // previous phase-detector sample in a sweep

    logic [NSTEP_BITS-1:0] cnt_sel, up_dist, pos_up, pos_dn;
    logic                  dec_sel, err_sel;

    // The position register is the only view of the MMCM phase, so outputs are
    // plain decodes of the state register.
    assign cmd_ready_o = (state == IDLE) && mmcm_locked_i;
    assign busy_o      = (state != IDLE);
    assign ps_en_o     = (state == ISSUE);

`ifdef TURFIO_PS_SCAN_DEC_EN
    assign ps_incdec_o = ~dec;
`else
    assign ps_incdec_o = 1'b1;
`endif

    // Neighbouring positions, wrapping at one RXCLK period.
    assign pos_up = (pos_o == SMAX) ? '0 : pos_o + NSTEP_BITS'(1);
    assign pos_dn = (pos_o == '0) ? SMAX : pos_o - NSTEP_BITS'(1);

    // Forward distance to the goto target; intermediate wrap in NSTEP_BITS is
    // harmless because the true result is always below STEPS_PER_CYCLE.
    assign up_dist = (cmd_arg_i >= pos_o) ? cmd_arg_i - pos_o
                                          : cmd_arg_i + SPC_N - pos_o;

`ifdef TURFIO_PS_SCAN_DEC_EN
    logic [NSTEP_BITS-1:0] dn_dist;
    assign dn_dist = (pos_o >= cmd_arg_i) ? pos_o - cmd_arg_i
                                          : pos_o + SPC_N - cmd_arg_i;
`endif

    // Decode the offered command into step count, direction and error.
    always_comb begin
        cnt_sel = '0;
        dec_sel = 1'b0;
        err_sel = 1'b0;
        case (cmd_op_i)
            2'b00: begin
`ifdef TURFIO_PS_SCAN_DEC_EN
                dec_sel = cmd_arg_i[NSTEP_BITS-1];
                cnt_sel = dec_sel ? (~cmd_arg_i + NSTEP_BITS'(1)) : cmd_arg_i;
`else
                cnt_sel = cmd_arg_i;
`endif
            end
            2'b01: cnt_sel = SPC_N;
            2'b10: begin
                if (cmd_arg_i >= SPC_N) err_sel = 1'b1;
`ifdef TURFIO_PS_SCAN_DEC_EN
                else if (dn_dist < up_dist) begin
                    dec_sel = 1'b1;
                    cnt_sel = dn_dist;
                end
`endif
                else cnt_sel = up_dist;
            end
            default: err_sel = 1'b1;
        endcase
    end

    // Command FSM: issue one PSEN per step, wait for PSDONE, settle and sample on sweeps.
    always_ff @(posedge ps_clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            pos_o        <= '0;
            edge_o       <= '0;
            edge_valid_o <= 1'b0;
            err_o        <= 1'b0;
            remaining    <= '0;
            timer        <= '0;
            dec          <= 1'b0;
            sweeping     <= 1'b0;
            prev         <= 1'b0;
        end else if (!mmcm_locked_i) begin
            // Losing lock resets the MMCM phase, so our notion of position is void.
            state        <= IDLE;
            pos_o        <= '0;
            edge_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        err_o     <= err_sel;
                        dec       <= dec_sel;
                        remaining <= cnt_sel;
                        sweeping  <= (cmd_op_i == 2'b01);
                        if (cmd_op_i == 2'b01) begin
                            edge_valid_o <= 1'b0;
                            prev         <= sample_i;  // sample at the starting position
                        end
                        if (!err_sel && cnt_sel != '0) state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (ps_done_i) begin
                        pos_o     <= dec ? pos_dn : pos_up;
                        remaining <= remaining - NSTEP_BITS'(1);
                        timer     <= '0;
                        if (sweeping)                          state <= SETTLE;
                        else if (remaining == NSTEP_BITS'(1))  state <= IDLE;
                        else                                   state <= ISSUE;
                    end else if (timer == TW'(DONE_TIMEOUT - 1)) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SETTLE: begin
                    if (timer == TW'(NSETTLE - 1)) state <= SAMPLE;
                    else                           timer <= timer + TW'(1);
                end
                SAMPLE: begin
                    // Only the first rising transition of the sweep is kept.
                    if (!edge_valid_o && !prev && sample_i) begin
                        edge_o       <= pos_o;
                        edge_valid_o <= 1'b1;
                    end
                    prev  <= sample_i;
                    state <= (remaining == '0) ? IDLE : ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
